calc_core: RTL and testbench
============================

CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter WIDTH, default 32: accumulator and datapath width (>=8).
REQ-002 Parameter IMM_W, default 16: immediate field width (<=WIDTH), sign-extended to WIDTH.
REQ-003 Parameter NACC, default 4: number of accumulators (power of 2, >=2); AW = log2(NACC).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 instr_valid  input  1  instruction present on instr.
REQ-007 instr_ready  output  1  core can accept an instruction this cycle.
REQ-008 instr  input  3+AW+2*IMM_W  {op[2:0], acc_idx[AW-1:0], immA[IMM_W-1:0], immB[IMM_W-1:0]}, MSB first.
REQ-009 sat_en  input  1  saturate on signed overflow when 1, wrap when 0; sampled at accept.
REQ-010 clr_ovf  input  1  clears sticky overflow flag.
REQ-011 rd_sel  input  AW  accumulator selected onto rd_data.
REQ-012 rd_data  output  WIDTH  combinational read of acc[rd_sel].
REQ-013 pc  output  WIDTH  count of accepted instructions.
REQ-014 result_valid  output  1  one-cycle pulse after an accumulator write.
REQ-015 ovf  output  1  sticky signed-overflow flag.
REQ-016 busy  output  1  high in EXEC or MUL state.
REQ-017 halted  output  1  high in HALT state.

Function
REQ-018 States: IDLE, EXEC, MUL, HALT; instr_ready=1 only in IDLE.
REQ-019 Accept = instr_valid & instr_ready; latches instr and sat_en; pc <= pc+1 (wraps at 2^WIDTH); IDLE->EXEC, except op MUL -> MUL and op HALT -> HALT.
REQ-020 Ops (A=sext(immA), B=sext(immB), X=acc[acc_idx]): 000 NOP; 001 X<=A+B; 010 X<=A-B; 011 X<=A+X; 100 X<=A-X; 101 X<=0; 110 X<=X*A (signed); 111 HALT.
REQ-021 EXEC: single cycle; writes X on its clock edge (NOP writes nothing); returns to IDLE.
REQ-022 result_valid high in the cycle after any write (ops 001-110), 0 otherwise; NOP produces no pulse.
REQ-023 Single-cycle throughput: one instruction per 2 cycles with instr_valid held high.
REQ-024 MUL: iterative shift-add over 2*WIDTH-bit product, exactly WIDTH cycles in MUL, then write and return to IDLE; latency accept-to-result_valid = WIDTH+1 cycles.
REQ-025 Overflow: add/sub signed overflow, or MUL product not representable in signed WIDTH; sets ovf.
REQ-026 On overflow with sat_en=1: result clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative); sat_en=0: low WIDTH bits.
REQ-027 ovf cleared by clr_ovf; if overflow and clr_ovf occur same cycle, ovf=1.
REQ-028 HALT: no further accepts, no writes; exits only via reset.
REQ-029 instr_valid while not ready is ignored; instr need not be held stable after accept.
REQ-030 rd_data reflects a write on the cycle after the writing edge (same cycle as result_valid).

Reset
REQ-031 rst_n low asynchronously forces: state IDLE, all accumulators 0, pc 0, ovf 0, result_valid 0, busy 0, halted 0.
REQ-032 Reset mid-MUL or mid-EXEC aborts the operation; no accumulator write completes.
REQ-033 After rst_n rises, instr_ready=1 on the first clock edge's cycle.

Verification
REQ-034 Reset, issue ADD acc0 A=5 B=-3 -> result_valid 2 cycles after accept, acc0=2, pc=1, ovf=0.
REQ-035 SUB acc1 A=0x7FFF, then ADD_ACC acc1 A=0x7FFF repeated until overflow with sat_en=1 (WIDTH=16, IMM_W=16) -> acc1 clamps to 0x7FFF, ovf=1; clr_ovf -> ovf=0.
REQ-036 acc2=-7, MUL acc2 A=6 -> busy for 32 cycles, result_valid at accept+33, acc2=-42 (0xFFFFFFD6).
REQ-037 Back-to-back instr_valid: 4 ADDs -> instr_ready alternates 1/0, pc=4 after 8 cycles.
REQ-038 HALT then valid ADD -> halted=1, instr_ready=0, no writes; rst_n low -> all state zeroed.
REQ-039 Assert rst_n low 10 cycles into MUL -> acc unchanged at 0, no result_valid, state IDLE.

Source files
------------

// File: rtl/calc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : calc_core                                                 |
// | Purpose  : Small accumulator machine. It takes one instruction at a  |
// |            time, does single-cycle add/sub/clear, does a signed      |
// |            multiply with an iterative shift-add, saturates or wraps  |
// |            on overflow, and can halt.                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module calc_core #(
    parameter int WIDTH = 32,
    parameter int IMM_W = 16,
    parameter int NACC  = 4,
    localparam int AW   = $clog2(NACC),
    localparam int IW   = 3 + AW + 2 * IMM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [IW-1:0]    instr,
    input  logic             sat_en,
    input  logic             clr_ovf,
    input  logic [AW-1:0]    rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] pc,
    output logic             result_valid,
    output logic             ovf,
    output logic             busy,
    output logic             halted
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] c_OP_NOP  = 3'b000;
    localparam logic [2:0] c_OP_ADD  = 3'b001;
    localparam logic [2:0] c_OP_SUB  = 3'b010;
    localparam logic [2:0] c_OP_ADDX = 3'b011;
    localparam logic [2:0] c_OP_SUBX = 3'b100;
    localparam logic [2:0] c_OP_CLR  = 3'b101;
    localparam logic [2:0] c_OP_MUL  = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    localparam logic [WIDTH-1:0] c_SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_ready;
    logic               r_busy;
    logic               r_halted;
    logic               r_result_valid;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   r_acc [NACC];

    // Latched instruction
    logic [2:0]         r_op;
    logic [AW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sat;

    // Iterative multiplier: unsigned magnitudes, sign applied at the end
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic [CW-1:0]      r_cnt;

    logic [2:0]         w_op;
    logic [AW-1:0]      w_idx;
    logic [IMM_W-1:0]   w_imm_a;
    logic [IMM_W-1:0]   w_imm_b;
    logic [WIDTH-1:0]   w_a_sext;
    logic [WIDTH-1:0]   w_b_sext;
    logic               w_accept;
    logic [WIDTH-1:0]   w_x_acc;
    logic [WIDTH-1:0]   w_abs_x;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_x_exec;
    logic [WIDTH:0]     w_sum;
    logic               w_exec_wr;
    logic               w_exec_ovf;
    logic [2*WIDTH-1:0] w_prod_step;
    logic [2*WIDTH-1:0] w_prod_signed;
    logic [WIDTH:0]     w_mul_hi;
    logic               w_mul_ovf;
    logic               w_mul_last;
    logic               w_wr_en;
    logic               w_wr_ovf;
    logic [WIDTH-1:0]   w_wr_data;

    assign w_op     = instr[IW-1 -: 3];
    assign w_idx    = instr[2*IMM_W +: AW];
    assign w_imm_a  = instr[IMM_W +: IMM_W];
    assign w_imm_b  = instr[0 +: IMM_W];
    assign w_a_sext = WIDTH'($signed(w_imm_a));
    assign w_b_sext = WIDTH'($signed(w_imm_b));
    assign w_accept = instr_valid & r_ready;

    // Multiply operands are taken from the accept cycle. -2^(WIDTH-1) has a
    // magnitude of 2^(WIDTH-1), which still fits as an unsigned WIDTH value.
    assign w_x_acc  = r_acc[w_idx];
    assign w_abs_x  = w_x_acc[WIDTH-1]  ? (~w_x_acc + WIDTH'(1))  : w_x_acc;
    assign w_abs_a  = w_a_sext[WIDTH-1] ? (~w_a_sext + WIDTH'(1)) : w_a_sext;
    assign w_x_exec = r_acc[r_idx];

    assign instr_ready  = r_ready;
    assign busy         = r_busy;
    assign halted       = r_halted;
    assign result_valid = r_result_valid;
    assign ovf          = r_ovf;
    assign pc           = r_pc;
    assign rd_data      = r_acc[rd_sel];

    // Single-cycle ALU with one guard bit to detect signed overflow
    always_comb begin
        w_sum     = '0;
        w_exec_wr = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_sum     = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
                w_exec_wr = 1'b1;
            end
            c_OP_SUB: begin
                w_sum     = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
                w_exec_wr = 1'b1;
            end
            c_OP_ADDX: begin
                w_sum     = {r_a[WIDTH-1], r_a} + {w_x_exec[WIDTH-1], w_x_exec};
                w_exec_wr = 1'b1;
            end
            c_OP_SUBX: begin
                w_sum     = {r_a[WIDTH-1], r_a} - {w_x_exec[WIDTH-1], w_x_exec};
                w_exec_wr = 1'b1;
            end
            c_OP_CLR: begin
                w_sum     = '0;
                w_exec_wr = 1'b1;
            end
            default: begin
                w_sum     = '0;
                w_exec_wr = 1'b0;
            end
        endcase
    end

    assign w_exec_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];

    // The last shift-add step is folded into the write so the product lands
    // on the edge that ends the final MUL cycle. The exact product magnitude
    // is at most 2^(2*WIDTH-2), so bit 2*WIDTH-1 is the true sign.
    assign w_prod_step   = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_prod_signed = r_neg ? (~w_prod_step + (2*WIDTH)'(1)) : w_prod_step;
    assign w_mul_hi      = w_prod_signed[2*WIDTH-1:WIDTH-1];
    assign w_mul_ovf     = ~((&w_mul_hi) | ~(|w_mul_hi));
    assign w_mul_last    = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));

    // Select the accumulator write source and apply saturation
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_ovf  = 1'b0;
        w_wr_data = '0;
        if ((r_state == S_EXEC) && w_exec_wr) begin
            w_wr_en   = 1'b1;
            w_wr_ovf  = w_exec_ovf;
            if (w_exec_ovf && r_sat) begin
                w_wr_data = w_sum[WIDTH] ? c_SAT_MIN : c_SAT_MAX;
            end else begin
                w_wr_data = w_sum[WIDTH-1:0];
            end
        end else if (w_mul_last) begin
            w_wr_en   = 1'b1;
            w_wr_ovf  = w_mul_ovf;
            if (w_mul_ovf && r_sat) begin
                w_wr_data = w_prod_signed[2*WIDTH-1] ? c_SAT_MIN : c_SAT_MAX;
            end else begin
                w_wr_data = w_prod_signed[WIDTH-1:0];
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_op == c_OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end else if (w_op == c_OP_HALT) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC:  w_state_nxt = S_IDLE;
            S_MUL:   w_state_nxt = w_mul_last ? S_IDLE : S_MUL;
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt == S_IDLE);
            r_busy   <= (w_state_nxt == S_EXEC) || (w_state_nxt == S_MUL);
            r_halted <= (w_state_nxt == S_HALT);
        end
    end

    // Capture the instruction and count it on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= c_OP_NOP;
            r_idx <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sat <= 1'b0;
            r_pc  <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_idx <= w_idx;
            r_a   <= w_a_sext;
            r_b   <= w_b_sext;
            r_sat <= sat_en;
            r_pc  <= r_pc + WIDTH'(1);
        end
    end

    // Shift-add multiplier: load on accept, one partial product per MUL cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept && (w_op == c_OP_MUL)) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_abs_x};
            r_mplier <= w_abs_a;
            r_prod   <= '0;
            r_neg    <= w_x_acc[WIDTH-1] ^ w_a_sext[WIDTH-1];
            r_cnt    <= '0;
        end else if (r_state == S_MUL) begin
            r_prod   <= w_prod_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // Accumulator file, result pulse and sticky overflow (a set beats a clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NACC; i++) begin
                r_acc[i] <= '0;
            end
            r_result_valid <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_result_valid <= w_wr_en;
            if (w_wr_en) begin
                r_acc[r_idx] <= w_wr_data;
            end
            if (w_wr_en && w_wr_ovf) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_calc_core                                              |
// | Purpose  : Scoreboard bench for calc_core with a behavioural model   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_calc_core;

    localparam int W    = 32;
    localparam int IMM  = 16;
    localparam int NACC = 4;
    localparam int AW   = 2;
    localparam int IW   = 3 + AW + 2 * IMM;

    localparam longint c_MAX = (longint'(1) << (W - 1)) - 1;
    localparam longint c_MIN = -(longint'(1) << (W - 1));

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [IW-1:0] instr = '0;
    logic          sat_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [AW-1:0] rd_sel;
    logic [AW-1:0] main_sel = '0;
    logic [AW-1:0] mon_sel = '0;
    logic          mon_active = 1'b0;
    logic          instr_ready;
    logic [W-1:0]  rd_data;
    logic [W-1:0]  pc;
    logic          result_valid;
    logic          ovf;
    logic          busy;
    logic          halted;

    assign rd_sel = mon_active ? mon_sel : main_sel;

    calc_core #(.WIDTH(W), .IMM_W(IMM), .NACC(NACC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .sat_en       (sat_en),
        .clr_ovf      (clr_ovf),
        .rd_sel       (rd_sel),
        .rd_data      (rd_data),
        .pc           (pc),
        .result_valid (result_valid),
        .ovf          (ovf),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] val;
        logic         ovf;
        logic [W-1:0] pc;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         e_mon;
    logic [W-1:0] m_acc [NACC];
    logic         m_ovf;
    logic [W-1:0] m_pc;
    int           last_acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NACC; i++) m_acc[i] = '0;
        m_ovf = 1'b0;
        m_pc  = '0;
        sb.delete();
    endtask

    // Reference: exact signed arithmetic in 64 bits, then range-check
    task automatic model_apply(input logic [2:0] op, input int idx, input logic [IMM-1:0] a,
                               input logic [IMM-1:0] b, input logic sat, input int c);
        longint la, lb, lx, r;
        bit wr, of;
        logic [W-1:0] v;
        exp_t e;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        lx = longint'($signed(m_acc[idx]));
        wr = 1'b1;
        r  = 0;
        case (op)
            3'd1: r = la + lb;
            3'd2: r = la - lb;
            3'd3: r = la + lx;
            3'd4: r = la - lx;
            3'd5: r = 0;
            3'd6: r = lx * la;
            default: wr = 1'b0;
        endcase
        m_pc = m_pc + 1;
        if (wr) begin
            of = (r > c_MAX) || (r < c_MIN);
            if (of && sat) v = (r < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            else           v = r[W-1:0];
            if (of) m_ovf = 1'b1;
            m_acc[idx] = v;
            e.idx = idx;
            e.val = v;
            e.ovf = m_ovf;
            e.pc  = m_pc;
            e.cyc = c + ((op == 3'd6) ? W + 1 : 2);
            sb.push_back(e);
        end
    endtask

    // Waits for ready (driving ignored junk meanwhile), then presents one instruction
    task automatic issue(input logic [2:0] op, input int idx, input logic [IMM-1:0] a,
                         input logic [IMM-1:0] b, input logic sat);
        int n = 0;
        while (!instr_ready && n < 200) begin
            instr_valid = 1'b1;
            instr       = IW'({$urandom, $urandom});
            @(negedge clk);
            n++;
        end
        chk("issue_ready", instr_ready, 1);
        if (instr_ready) begin
            instr       = {op, AW'(idx), a, b};
            instr_valid = 1'b1;
            sat_en      = sat;
            model_apply(op, idx, a, b, sat, cyc);
            last_acc_cyc = cyc + 1;
            @(negedge clk);
            chk("ready_after_accept", instr_ready, 0);
        end
        instr_valid = 1'b0;
        instr       = IW'({$urandom, $urandom});
        sat_en      = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !instr_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", n < 200, 1);
    endtask

    task automatic check_accs_zero(input string name);
        for (int i = 0; i < NACC; i++) begin
            main_sel = AW'(i);
            #1;
            chk(name, rd_data, 0);
        end
    endtask

    // Monitor: every result pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && result_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                e_mon      = sb.pop_front();
                mon_sel    = AW'(e_mon.idx);
                mon_active = 1'b1;
                #1;
                chk("acc", rd_data, e_mon.val);
                chk("ovf", ovf, e_mon.ovf);
                chk("pc", pc, e_mon.pc);
                chk("latency", cyc, e_mon.cyc);
                mon_active = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_c[4];
        int n;
        logic [W-1:0] pc0;
        logic [2:0] op;
        int r;

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        chk("rst_pc", pc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_rv", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        rst_n = 1'b1;
        check_accs_zero("rst_acc");

        // ADD acc0 5 + -3
        issue(3'd1, 0, 16'd5, 16'hFFFD, 1'b0);
        wait_idle();

        // Overflow, saturation, wrap and flag clearing on acc1
        issue(3'd1, 1, 16'h4000, 16'h4000, 1'b0);
        issue(3'd6, 1, 16'h4000, 16'h0000, 1'b1);
        issue(3'd6, 1, 16'h0004, 16'h0000, 1'b1);
        issue(3'd3, 1, 16'h7FFF, 16'h0000, 1'b1);
        wait_idle();
        chk("ovf_set", ovf, 1);
        clr_ovf = 1'b1;
        m_ovf   = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clear", ovf, 0);
        clr_ovf = 1'b1;
        issue(3'd3, 1, 16'h7FFF, 16'h0000, 1'b0);
        @(negedge clk);
        clr_ovf = 1'b0;
        wait_idle();
        issue(3'd4, 1, 16'h7FFF, 16'h0000, 1'b1);
        issue(3'd4, 1, 16'hFFFE, 16'h0000, 1'b1);
        issue(3'd6, 1, 16'hFFFF, 16'h0000, 1'b0);
        issue(3'd6, 1, 16'h0002, 16'h0000, 1'b1);
        wait_idle();

        // acc2 = -7, then MUL by 6
        issue(3'd1, 2, 16'hFFF9, 16'h0000, 1'b0);
        issue(3'd6, 2, 16'h0006, 16'h0000, 1'b0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", n, W);
        wait_idle();

        // Back-to-back with valid held high
        pc0 = pc;
        for (int k = 0; k < 4; k++) begin
            issue(3'd1, k, 16'($urandom), 16'($urandom), 1'b0);
            acc_c[k] = last_acc_cyc;
        end
        for (int k = 1; k < 4; k++) chk("b2b_spacing", acc_c[k] - acc_c[k-1], 2);
        wait_idle();
        chk("b2b_pc", pc - pc0, 4);

        // Randomized instruction stream
        for (int i = 0; i < 150; i++) begin
            r  = $urandom_range(0, 99);
            op = (r < 8) ? 3'd0 : (r < 26) ? 3'd1 : (r < 42) ? 3'd2 : (r < 58) ? 3'd3 :
                 (r < 72) ? 3'd4 : (r < 80) ? 3'd5 : 3'd6;
            issue(op, $urandom_range(0, 3), 16'($urandom), 16'($urandom), 1'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                wait_idle();
                clr_ovf = 1'b1;
                m_ovf   = 1'b0;
                @(negedge clk);
                clr_ovf = 1'b0;
                chk("rand_ovf_clr", ovf, 0);
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        wait_idle();
        chk("rand_pc", pc, m_pc);

        // HALT, then an ignored ADD, then asynchronous reset
        issue(3'd7, 0, 16'h0000, 16'h0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            instr_valid = 1'b1;
            instr       = {3'd1, AW'(k % NACC), 16'h0011, 16'h0022};
            @(negedge clk);
        end
        chk("halt_halted", halted, 1);
        chk("halt_ready", instr_ready, 0);
        chk("halt_busy", busy, 0);
        chk("halt_pc", pc, m_pc);
        instr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("halt_rst_pc", pc, 0);
        chk("halt_rst_halted", halted, 0);
        chk("halt_rst_ovf", ovf, 0);
        chk("halt_rst_ready", instr_ready, 1);
        check_accs_zero("halt_rst_acc");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset ten cycles into a MUL
        issue(3'd6, 0, 16'h0007, 16'h0000, 1'b0);
        repeat (9) @(negedge clk);
        chk("mid_mul_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_rv", result_valid, 0);
        chk("abort_ready", instr_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_pc", pc, 0);
        chk("abort_idle", instr_ready, 1);
        check_accs_zero("abort_acc");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
